// File: rtl/hub75_pkg.sv
// Shared constants and types for the HUB75 panel path.
// Panel geometry, default pixel-word format and the SPI frame receiver state encoding.
// Ports: none (package).
package hub75_pkg;

  // Panel geometry
  localparam int PANEL_COLUMNS        = 64;
  localparam int PANEL_ROWS           = 32;
  localparam int PIXELS_PER_FRAME_DEF = PANEL_COLUMNS * PANEL_ROWS;

  // Pixel word: 4 bits each of R, G, B and a spare nibble
  localparam int BITS_PER_PIXEL_DEF   = 16;

  // Pixel index width; one extra bit on the RAM address selects the buffer half
  localparam int ADDR_WIDTH_DEF       = 11;

  // Frame receiver states
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACTIVE  = 2'd1,
    DISCARD = 2'd2
  } rx_state_t;

  // Width of a counter that must hold the value n itself
  function automatic int count_width(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/spi_frame_receiver_if.sv
// SPI-in / pixel-RAM-write-out bundle of the frame receiver.
// master: the SPI host side (drives spi_*, observes the write port and frame status).
// slave:  the receiver (samples spi_*, drives wr_*, disp_buf, frame_done, frame_err).
interface spi_frame_receiver_if #(
  parameter int BITS_PER_PIXEL = hub75_pkg::BITS_PER_PIXEL_DEF,
  parameter int ADDR_WIDTH     = hub75_pkg::ADDR_WIDTH_DEF
);

  // SPI side, asynchronous to the system clock
  logic                      spi_clk;
  logic                      spi_mosi;
  logic                      spi_ss;

  // Pixel RAM write port: {write buffer bit, pixel index}
  logic                      wr_en;
  logic [ADDR_WIDTH:0]       wr_addr;
  logic [BITS_PER_PIXEL-1:0] wr_data;

  // Frame status
  logic                      disp_buf;
  logic                      frame_done;
  logic                      frame_err;

  modport master (
    output spi_clk, spi_mosi, spi_ss,
    input  wr_en, wr_addr, wr_data, disp_buf, frame_done, frame_err
  );

  modport slave (
    input  spi_clk, spi_mosi, spi_ss,
    output wr_en, wr_addr, wr_data, disp_buf, frame_done, frame_err
  );

endinterface

// File: rtl/sync_edge.sv
// 2-FF synchroniser plus history flop; gives the synchronised level and single-cycle rise/fall.
// Latency: a change present before clk edge N shows on level/rise/fall after edge N+1.
// Backpressure: none, free-running.
// Ports: clk, n_reset (sync, active low), din (async in), level, rise, fall.
module sync_edge #(
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic n_reset,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);

  logic meta;
  logic sync;
  logic hist;

  always_ff @(posedge clk) begin
    if (!n_reset) begin
      meta <= RESET_VAL;
      sync <= RESET_VAL;
      hist <= RESET_VAL;
    end else begin
      meta <= din;
      sync <= meta;
      hist <= sync;
    end
  end

  assign level = sync;
  assign rise  = sync & ~hist;
  assign fall  = ~sync & hist;

endmodule

// File: rtl/spi_frame_receiver.sv
// SPI (mode 0, MSB first, ss active low) pixel-frame receiver writing into a double-buffered RAM.
// Latency: wr_en is visible after clk edge N+3 when the last bit's spi_clk rise precedes edge N.
// Backpressure: none; the RAM accepts every strobe, spi_clk must be <= clk/4.
// Ports: clk, n_reset (sync, active low), bus (spi_frame_receiver_if.slave).
module spi_frame_receiver
  import hub75_pkg::*;
#(
  parameter int BITS_PER_PIXEL   = BITS_PER_PIXEL_DEF,
  parameter int PIXELS_PER_FRAME = PIXELS_PER_FRAME_DEF,
  parameter int ADDR_WIDTH       = ADDR_WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  n_reset,
  spi_frame_receiver_if.slave   bus
);

  localparam int CNT_W = count_width(BITS_PER_PIXEL);
  localparam int PIX_W = ADDR_WIDTH + 1;

  localparam logic [CNT_W-1:0] BIT_FULL = CNT_W'(BITS_PER_PIXEL);
  localparam logic [PIX_W-1:0] PIX_FULL = PIX_W'(PIXELS_PER_FRAME);

  // ---------------------------------------------------------------------------
  // Input conditioning: equal-depth synchronisers keep MOSI aligned with the
  // detected spi_clk edge.
  // ---------------------------------------------------------------------------
  logic sclk_rise;
  logic sclk_level_unused;
  logic sclk_fall_unused;
  logic mosi_level;
  logic mosi_rise_unused;
  logic mosi_fall_unused;
  logic ss_rise;
  logic ss_fall;
  logic ss_level_unused;

  sync_edge #(.RESET_VAL(1'b0)) u_sync_sclk (
    .clk     (clk),
    .n_reset (n_reset),
    .din     (bus.spi_clk),
    .level   (sclk_level_unused),
    .rise    (sclk_rise),
    .fall    (sclk_fall_unused)
  );

  sync_edge #(.RESET_VAL(1'b0)) u_sync_mosi (
    .clk     (clk),
    .n_reset (n_reset),
    .din     (bus.spi_mosi),
    .level   (mosi_level),
    .rise    (mosi_rise_unused),
    .fall    (mosi_fall_unused)
  );

  // ss resets to the asserted (low) level: if ss is already low when reset
  // releases no falling edge is seen, so a frame only starts after ss has
  // gone high and low again. A release with ss high yields a rise that IDLE
  // ignores.
  sync_edge #(.RESET_VAL(1'b0)) u_sync_ss (
    .clk     (clk),
    .n_reset (n_reset),
    .din     (bus.spi_ss),
    .level   (ss_level_unused),
    .rise    (ss_rise),
    .fall    (ss_fall)
  );

  // ---------------------------------------------------------------------------
  // Frame state machine
  // ---------------------------------------------------------------------------
  rx_state_t                 state;
  logic [CNT_W-1:0]          bit_cnt;
  logic [PIX_W-1:0]          pix_idx;
  logic [BITS_PER_PIXEL-1:0] shift_reg;

  logic                      wr_en_q;
  logic [ADDR_WIDTH:0]       wr_addr_q;
  logic [BITS_PER_PIXEL-1:0] wr_data_q;
  logic                      disp_buf_q;
  logic                      frame_done_q;
  logic                      frame_err_q;

  always_ff @(posedge clk) begin
    if (!n_reset) begin
      state        <= IDLE;
      bit_cnt      <= '0;
      pix_idx      <= '0;
      shift_reg    <= '0;
      wr_en_q      <= 1'b0;
      wr_addr_q    <= '0;
      wr_data_q    <= '0;
      disp_buf_q   <= 1'b0;
      frame_done_q <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      // Strobes last one cycle; address and data hold between strobes.
      wr_en_q      <= 1'b0;
      frame_done_q <= 1'b0;
      frame_err_q  <= 1'b0;

      case (state)
        IDLE: begin
          if (ss_fall) begin
            bit_cnt <= '0;
            pix_idx <= '0;
            state   <= ACTIVE;
          end
        end

        ACTIVE: begin
          if (ss_rise) begin
            // ss rise takes priority over a coincident spi_clk rise; that bit
            // is dropped.
            if (pix_idx == PIX_FULL && bit_cnt == '0) begin
              disp_buf_q   <= ~disp_buf_q;
              frame_done_q <= 1'b1;
            end else begin
              frame_err_q  <= 1'b1;
            end
            state <= IDLE;
          end else if (bit_cnt == BIT_FULL) begin
            // Word completed on the previous cycle's shift; commit it now.
            bit_cnt <= '0;
            if (pix_idx == PIX_FULL) begin
              // One word too many: the frame can no longer be accepted.
              state <= DISCARD;
            end else begin
              wr_en_q   <= 1'b1;
              wr_data_q <= shift_reg;
              wr_addr_q <= {~disp_buf_q, pix_idx[ADDR_WIDTH-1:0]};
              pix_idx   <= pix_idx + 1'b1;
            end
          end else if (sclk_rise) begin
            shift_reg <= {shift_reg[BITS_PER_PIXEL-2:0], mosi_level};
            bit_cnt   <= bit_cnt + 1'b1;
          end
        end

        DISCARD: begin
          if (ss_rise) begin
            frame_err_q <= 1'b1;
            state       <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

  assign bus.wr_en      = wr_en_q;
  assign bus.wr_addr    = wr_addr_q;
  assign bus.wr_data    = wr_data_q;
  assign bus.disp_buf   = disp_buf_q;
  assign bus.frame_done = frame_done_q;
  assign bus.frame_err  = frame_err_q;

endmodule
